branch_cond_unit: RTL and testbench

Registered branch-condition evaluator for the datapath control path. It samples a condition code from the instruction register and one or two operands from the bus, and evaluates one of eight conditions. The one-bit branch decision is held in a flip-flop that the control unit reads to gate the PC load. It is a width-parametrised successor of the single-operand conditional flip-flop. It adds two-operand compare modes sequenced over two bus cycles, plus a valid/acknowledge handshake.

---
 rtl/branch_cond_unit.sv | 102 ++++++++++
 tb/tb_branch_cond_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Registered branch-condition evaluator: single-operand zero/sign tests and
// two-operand signed compares sequenced over two bus cycles, with a valid/ack handshake.
//
// state  | meaning
// IDLE   | no fresh result; con_ff_out holds the last decision
// WAIT_B | operand A and condition latched, waiting for operand B
// VALID  | con_ff_out holds a fresh result not yet acknowledged
module branch_cond_unit #(
    parameter int WIDTH    = 32,
    parameter int IR_WIDTH = 32,
    parameter int COND_LSB = 19
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                con_in,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [WIDTH-1:0]    bus_in,
    input  logic                con_ack,
    output logic                con_ff_out,
    output logic                con_valid,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_B = 2'd1;
    localparam logic [1:0] ST_VALID  = 2'd2;

    logic [1:0]       state;
    logic [2:0]       condCode;
    logic [WIDTH-1:0] opA;
    logic [2:0]       irCode;
    logic             isPairCode;
    logic             unusedBits;

    assign irCode     = ir_in[COND_LSB+2:COND_LSB];
    assign isPairCode = (irCode[2:1] == 2'b11);

    // Only the condition field of ir_in and the compare-select bit of the
    // latched code are consumed; the rest is folded into an unused sink.
    assign unusedBits = ^{ir_in, condCode};

    function automatic logic evalSingle(input logic [2:0] code, input logic [WIDTH-1:0] a);
        logic aZero;
        logic aNeg;
        aZero = (a == '0);
        aNeg  = a[WIDTH-1];
        case (code)
            3'b000:  return aZero;
            3'b001:  return !aZero;
            3'b010:  return !aNeg;
            3'b011:  return aNeg;
            3'b100:  return !aNeg && !aZero;
            3'b101:  return aNeg || aZero;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic evalPair(input logic isLt, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        if (isLt)
            return $signed(a) < $signed(b);
        return a == b;
    endfunction

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= ST_IDLE;
            condCode   <= 3'b000;
            opA        <= '0;
            con_ff_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_VALID: begin
                    if (con_in) begin
                        condCode <= irCode;
                        if (isPairCode) begin
                            opA   <= bus_in;
                            state <= ST_WAIT_B;
                        end else begin
                            con_ff_out <= evalSingle(irCode, bus_in);
                            state      <= ST_VALID;
                        end
                    end else if (state == ST_VALID && con_ack) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_B: begin
                    // Condition field is deliberately not re-sampled here.
                    if (con_in) begin
                        con_ff_out <= evalPair(condCode[0], opA, bus_in);
                        state      <= ST_VALID;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign con_valid = (state == ST_VALID);
    assign busy      = (state == ST_WAIT_B);

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: a 32-bit instance for the main
// scenarios and an 8-bit instance (COND_LSB=0) for the parameter sweep.
module tb_branch_cond_unit;

    logic        clock;
    logic        clear;
    logic        con_in;
    logic [31:0] ir_in;
    logic [31:0] bus_in;
    logic        con_ack;
    logic        con_ff_out;
    logic        con_valid;
    logic        busy;

    logic       con8;
    logic [7:0] ir8;
    logic [7:0] bus8;
    logic       ack8;
    logic       ff8;
    logic       valid8;
    logic       busy8;

    int checkCount;
    int passCount;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] bus;
        logic        cin;
        logic        ack;
        logic [2:0]  exp;   // {con_ff_out, con_valid, busy}
        string       tag;
    } step_t;

    typedef struct {
        logic [2:0] exp;
        string      tag;
    } exp_t;

    exp_t sbQ[$];

    branch_cond_unit #(.WIDTH(32), .IR_WIDTH(32), .COND_LSB(19)) dut (
        .clock(clock), .clear(clear), .con_in(con_in), .ir_in(ir_in),
        .bus_in(bus_in), .con_ack(con_ack), .con_ff_out(con_ff_out),
        .con_valid(con_valid), .busy(busy)
    );

    branch_cond_unit #(.WIDTH(8), .IR_WIDTH(8), .COND_LSB(0)) dut8 (
        .clock(clock), .clear(clear), .con_in(con8), .ir_in(ir8),
        .bus_in(bus8), .con_ack(ack8), .con_ff_out(ff8),
        .con_valid(valid8), .busy(busy8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input step_t s);
        ir_in        = '0;
        ir_in[21:19] = s.code;
        bus_in       = s.bus;
        con_in       = s.cin;
        con_ack      = s.ack;
    endtask

    task automatic test_reset();
        exp_t e;
        clear = 1'b1;
        #1;
        sbQ.push_back('{3'b000, "reset_initial"});
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        tick();
        clear = 1'b0;
        drive('{3'b000, 32'h0, 1'b1, 1'b0, 3'b110, "pre_reset_capture"});
        sbQ.push_back('{3'b110, "pre_reset_capture"});
        tick();
        con_in = 1'b0;
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        #2 clear = 1'b1;
        sbQ.push_back('{3'b000, "reset_async_midcycle"});
        #1;
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_zero_sign();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{3'b000, 32'h00000000, 1'b1, 1'b0, 3'b110, "eqz_0"});
        tbl.push_back('{3'b001, 32'h00000000, 1'b1, 1'b0, 3'b010, "nez_0"});
        tbl.push_back('{3'b010, 32'h80000000, 1'b1, 1'b0, 3'b010, "gez_min"});
        tbl.push_back('{3'b011, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b110, "ltz_m1"});
        tbl.push_back('{3'b100, 32'h00000000, 1'b1, 1'b0, 3'b010, "gtz_0"});
        tbl.push_back('{3'b101, 32'h00000000, 1'b1, 1'b0, 3'b110, "lez_0"});
        tbl.push_back('{3'b100, 32'h00000001, 1'b1, 1'b0, 3'b110, "gtz_1"});
        tbl.push_back('{3'b010, 32'h00000000, 1'b1, 1'b0, 3'b110, "gez_0"});
        tbl.push_back('{3'b101, 32'h80000000, 1'b1, 1'b0, 3'b110, "lez_min"});
        tbl.push_back('{3'b001, 32'h00000100, 1'b1, 1'b0, 3'b110, "nez_256"});
        tbl.push_back('{3'b100, 32'h7FFFFFFF, 1'b1, 1'b0, 3'b110, "gtz_max"});
        tbl.push_back('{3'b000, 32'h00000001, 1'b1, 1'b0, 3'b010, "eqz_1"});
        foreach (tbl[i]) begin
            drive(tbl[i]);
            sbQ.push_back('{tbl[i].exp, tbl[i].tag});
            tick();
            con_in  = 1'b0;
            con_ack = 1'b0;
            e = sbQ.pop_front();
            checkCount++;
            if ({con_ff_out, con_valid, busy} !== e.exp)
                $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
            else passCount++;
        end
    endtask

    // Entered in VALID with con_ff_out=0. Codes on B strobes must be ignored.
    task automatic test_two_operand();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{3'b111, 32'h80000000, 1'b1, 1'b0, 3'b001, "lt_a_min"});
        tbl.push_back('{3'b000, 32'h00000001, 1'b1, 1'b0, 3'b110, "lt_min_vs_1"});
        tbl.push_back('{3'b111, 32'h00000005, 1'b1, 1'b0, 3'b101, "lt_a_5"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b1, 3'b101, "waitb_ack_ignored"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b0, 3'b101, "waitb_hold"});
        tbl.push_back('{3'b000, 32'h00000005, 1'b1, 1'b0, 3'b010, "lt_5_vs_5"});
        tbl.push_back('{3'b110, 32'h00000005, 1'b1, 1'b0, 3'b001, "eq_a_5"});
        tbl.push_back('{3'b011, 32'h00000005, 1'b1, 1'b0, 3'b110, "eq_5_vs_5"});
        tbl.push_back('{3'b111, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b101, "lt_a_m1"});
        tbl.push_back('{3'b001, 32'h00000000, 1'b1, 1'b0, 3'b110, "lt_m1_vs_0"});
        tbl.push_back('{3'b111, 32'h00000001, 1'b1, 1'b0, 3'b101, "lt_a_1"});
        tbl.push_back('{3'b000, 32'h80000000, 1'b1, 1'b0, 3'b010, "lt_1_vs_min"});
        tbl.push_back('{3'b110, 32'h12345678, 1'b1, 1'b0, 3'b001, "eq_a_x"});
        tbl.push_back('{3'b110, 32'h12345679, 1'b1, 1'b0, 3'b010, "eq_x_vs_x1"});
        foreach (tbl[i]) begin
            drive(tbl[i]);
            sbQ.push_back('{tbl[i].exp, tbl[i].tag});
            tick();
            con_in  = 1'b0;
            con_ack = 1'b0;
            e = sbQ.pop_front();
            checkCount++;
            if ({con_ff_out, con_valid, busy} !== e.exp)
                $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
            else passCount++;
        end
    endtask

    task automatic test_handshake();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{3'b000, 32'h00000000, 1'b1, 1'b0, 3'b110, "hs_result1"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b1, 3'b100, "hs_ack_clears_valid"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b1, 3'b100, "hs_ack_in_idle"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b0, 3'b100, "hs_idle_hold"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b1, 1'b0, 3'b110, "hs_result1_again"});
        tbl.push_back('{3'b000, 32'h00000007, 1'b1, 1'b1, 3'b010, "hs_ack_and_capture"});
        tbl.push_back('{3'b110, 32'h00000003, 1'b1, 1'b1, 3'b001, "hs_ack_and_pair_capture"});
        tbl.push_back('{3'b110, 32'h00000003, 1'b1, 1'b0, 3'b110, "hs_pair_result"});
        tbl.push_back('{3'b000, 32'h00000000, 1'b0, 1'b1, 3'b100, "hs_final_ack"});
        foreach (tbl[i]) begin
            drive(tbl[i]);
            sbQ.push_back('{tbl[i].exp, tbl[i].tag});
            tick();
            con_in  = 1'b0;
            con_ack = 1'b0;
            e = sbQ.pop_front();
            checkCount++;
            if ({con_ff_out, con_valid, busy} !== e.exp)
                $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
            else passCount++;
        end
    endtask

    // Entered in IDLE with con_ff_out=1.
    task automatic test_reset_mid_pair();
        exp_t e;
        drive('{3'b110, 32'h00000009, 1'b1, 1'b0, 3'b101, "rm_capture_a"});
        sbQ.push_back('{3'b101, "rm_capture_a"});
        tick();
        con_in = 1'b0;
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        #2 clear = 1'b1;
        sbQ.push_back('{3'b000, "rm_clear_immediate"});
        #1;
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        tick();
        clear = 1'b0;
        sbQ.push_back('{3'b000, "rm_idle_after_release"});
        tick();
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
        drive('{3'b000, 32'h00000000, 1'b1, 1'b0, 3'b110, "rm_eqz_after"});
        sbQ.push_back('{3'b110, "rm_eqz_after"});
        tick();
        con_in = 1'b0;
        e = sbQ.pop_front();
        checkCount++;
        if ({con_ff_out, con_valid, busy} !== e.exp)
            $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {con_ff_out, con_valid, busy}, e.exp);
        else passCount++;
    endtask

    task automatic test_width8();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{3'b011, 32'h80, 1'b1, 1'b0, 3'b110, "w8_ltz_80"});
        tbl.push_back('{3'b011, 32'h7F, 1'b1, 1'b0, 3'b010, "w8_ltz_7f"});
        tbl.push_back('{3'b100, 32'h7F, 1'b1, 1'b0, 3'b110, "w8_gtz_7f"});
        tbl.push_back('{3'b111, 32'h80, 1'b1, 1'b0, 3'b101, "w8_lt_a_80"});
        tbl.push_back('{3'b000, 32'h01, 1'b1, 1'b0, 3'b110, "w8_lt_80_vs_01"});
        tbl.push_back('{3'b111, 32'h01, 1'b1, 1'b0, 3'b101, "w8_lt_a_01"});
        tbl.push_back('{3'b000, 32'hFF, 1'b1, 1'b0, 3'b010, "w8_lt_01_vs_ff"});
        foreach (tbl[i]) begin
            ir8  = {5'b00000, tbl[i].code};
            bus8 = tbl[i].bus[7:0];
            con8 = tbl[i].cin;
            ack8 = tbl[i].ack;
            sbQ.push_back('{tbl[i].exp, tbl[i].tag});
            tick();
            con8 = 1'b0;
            ack8 = 1'b0;
            e = sbQ.pop_front();
            checkCount++;
            if ({ff8, valid8, busy8} !== e.exp)
                $display("FAIL %s: got ff/valid/busy=%b expected %b", e.tag, {ff8, valid8, busy8}, e.exp);
            else passCount++;
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        con_in  = 1'b0;
        con_ack = 1'b0;
        ir_in   = '0;
        bus_in  = '0;
        con8    = 1'b0;
        ack8    = 1'b0;
        ir8     = '0;
        bus8    = '0;
        test_reset();
        test_zero_sign();
        test_two_operand();
        test_handshake();
        test_reset_mid_pair();
        test_width8();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
